// File: rtl/chacha_block_engine.sv
// chacha_block_engine: multi-block ChaCha keystream generator. Accepts one
// key/nonce/counter job, then emits num_blocks 512-bit blocks with the block
// counter advanced internally. Round count and quarter-round lanes are parameters.
module chacha_block_engine #(
    parameter int unsigned ROUNDS   = 20,
    parameter int unsigned QR_LANES = 4,
    parameter int unsigned NB_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [255:0]    key,
    input  logic [95:0]     nonce,
    input  logic [31:0]     counter_init,
    input  logic [NB_W-1:0] num_blocks,
    output logic [511:0]    block_out,
    output logic            block_valid,
    input  logic            block_ready,
    output logic [31:0]     block_ctr,
    output logic            last_block,
    output logic            busy,
    output logic            done,
    output logic            ctr_overflow,
    output logic [31:0]     blocks_produced
);

    localparam int unsigned N_CYC   = 4 * ROUNDS / QR_LANES;
    localparam int unsigned RC_W    = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [31:0] CTR_MAX = 32'hFFFF_FFFF;

    // Reject unsupported configurations at elaboration.
    generate
        if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
            $error("chacha_block_engine: ROUNDS must be 8, 12 or 20");
        end
        if (!(QR_LANES == 1 || QR_LANES == 2 || QR_LANES == 4)) begin : g_bad_lanes
            $error("chacha_block_engine: QR_LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_OUTPUT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [255:0]    key_q;
    logic [95:0]     nonce_q;
    logic [31:0]     ctr;
    logic [NB_W-1:0] remaining;
    logic [RC_W-1:0] rnd_cnt;
    logic [2:0]      qr_pos;
    logic [31:0]     work     [16];
    logic [31:0]     ff       [16];
    logic [31:0]     init_st  [16];
    logic [31:0]     work_rnd [16];
    logic [15:0]     qi;
    logic [127:0]    qo;
    logic            accept;
    logic            hs;
    logic            rnd_last;
    logic            more;
    logic            done_next;
    logic            ovf_set;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                   input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Word indices {a,b,c,d} as {row,col}; q<4 is a column, q>=4 a diagonal.
    function automatic logic [15:0] qr_index(input logic [2:0] q);
        logic [1:0] k;
        k = q[1:0];
        if (!q[2]) begin
            return {2'b00, k, 2'b01, k, 2'b10, k, 2'b11, k};
        end
        return {2'b00, k, 2'b01, 2'(k + 2'd1), 2'b10, 2'(k + 2'd2), 2'b11, 2'(k + 2'd3)};
    endfunction

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        ovf_set    = 1'b0;
        accept     = start_valid && start_ready && (state == S_IDLE);
        hs         = (state == S_OUTPUT) && block_ready;
        rnd_last   = (rnd_cnt == RC_W'(N_CYC - 1));
        more       = (remaining != NB_W'(1));
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (num_blocks != '0) state_next = S_LOAD;
                    else                  done_next  = 1'b1;
                end
            end
            S_LOAD:  state_next = S_ROUND;
            S_ROUND: if (rnd_last) state_next = S_ADD;
            S_ADD:   state_next = S_OUTPUT;
            S_OUTPUT: begin
                if (block_ready) begin
                    if (more && (ctr != CTR_MAX)) begin
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                        ovf_set    = more;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Initial block state: constants, key, counter, nonce.
    always_comb begin
        init_st[0]  = 32'h6170_7865;
        init_st[1]  = 32'h3320_646e;
        init_st[2]  = 32'h7962_2d32;
        init_st[3]  = 32'h6b20_6574;
        for (int i = 0; i < 8; i++) init_st[4 + i] = key_q[32 * i +: 32];
        init_st[12] = ctr;
        for (int i = 0; i < 3; i++) init_st[13 + i] = nonce_q[32 * i +: 32];
    end

    // Apply the next QR_LANES quarter-rounds; lanes in a group touch disjoint words.
    always_comb begin
        for (int i = 0; i < 16; i++) work_rnd[i] = work[i];
        qi = '0;
        qo = '0;
        for (int l = 0; l < int'(QR_LANES); l++) begin
            qi = qr_index(3'(qr_pos + 3'(l)));
            qo = quarter_round(work_rnd[qi[15:12]], work_rnd[qi[11:8]],
                               work_rnd[qi[7:4]], work_rnd[qi[3:0]]);
            work_rnd[qi[15:12]] = qo[127:96];
            work_rnd[qi[11:8]]  = qo[95:64];
            work_rnd[qi[7:4]]   = qo[63:32];
            work_rnd[qi[3:0]]   = qo[31:0];
        end
    end

    // State register, registered status outputs and job counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            start_ready     <= 1'b0;
            busy            <= 1'b0;
            block_valid     <= 1'b0;
            done            <= 1'b0;
            ctr_overflow    <= 1'b0;
            blocks_produced <= '0;
            remaining       <= '0;
            ctr             <= '0;
            rnd_cnt         <= '0;
            qr_pos          <= '0;
        end else begin
            state       <= state_next;
            start_ready <= (state_next == S_IDLE);
            busy        <= (state_next != S_IDLE);
            block_valid <= (state_next == S_OUTPUT);
            done        <= done_next;
            if (accept)       ctr_overflow <= 1'b0;
            else if (ovf_set) ctr_overflow <= 1'b1;
            if (hs) blocks_produced <= blocks_produced + 32'd1;
            if (accept) begin
                remaining <= num_blocks;
                ctr       <= counter_init;
            end else if (hs && (state_next == S_LOAD)) begin
                remaining <= remaining - NB_W'(1);
                ctr       <= ctr + 32'd1;
            end
            if (state == S_LOAD) begin
                rnd_cnt <= '0;
                qr_pos  <= '0;
            end else if (state == S_ROUND) begin
                rnd_cnt <= rnd_cnt + RC_W'(1);
                qr_pos  <= qr_pos + 3'(QR_LANES);
            end
        end
    end

    // Job inputs and working/feed-forward state.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_q   <= key;
            nonce_q <= nonce;
        end
        if (state == S_LOAD) begin
            for (int i = 0; i < 16; i++) begin
                work[i] <= init_st[i];
                ff[i]   <= init_st[i];
            end
        end else if (state == S_ROUND) begin
            for (int i = 0; i < 16; i++) work[i] <= work_rnd[i];
        end
    end

    // Output block register, held stable through OUTPUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            block_out  <= '0;
            block_ctr  <= '0;
            last_block <= 1'b0;
        end else if (state == S_ADD) begin
            for (int i = 0; i < 16; i++) block_out[32 * i +: 32] <= work[i] + ff[i];
            block_ctr  <= ctr;
            last_block <= !more || (ctr == CTR_MAX);
        end
    end

endmodule
